// File: rtl/cache_pkg.sv
// Shared cache/AXI definitions: bus widths, AXI response codes
// and the state encodings of the AXI4-Lite memory responder.
package cache_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int DATA_BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

endpackage

// File: rtl/axi_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), seeded with 16'hACE1,
// advancing every cycle; drives the optional ready stalls.
module axi_lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= 16'hACE1;
        else
            state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
    end

endmodule

// File: rtl/axi_4_lite_slave_mem.sv
// AXI4-Lite responder backed by a word-addressed memory, one outstanding
// read and write. Define AXI_SLV_BACKPRESSURE_EN for LFSR ready stalls.
module axi_4_lite_slave_mem
    import cache_pkg::*;
#(
    parameter int MEM_DEPTH    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                  aclk_i,
    input  logic                  arstn_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic [2:0]            awprot_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_BYTES-1:0] wstrb_i,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [1:0]            bresp_o,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [2:0]            arprot_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o
);

    localparam int OFF = $clog2(DATA_BYTES);
    localparam int IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> OFF) < ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t              w_state, w_next;
    r_state_t              r_state, r_next;
    logic                  rdy_en;
    logic                  gate;
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_BYTES-1:0] w_strb;
    logic [3:0]            r_cnt;
    axi_resp_t             bresp, rresp;
    logic                  aw_hs, w_hs, b_hs, ar_hs, commit, r_load;
    logic                  unused;

`ifdef AXI_SLV_BACKPRESSURE_EN
    logic [15:0] lfsr;

    axi_lfsr16 u_lfsr (
        .clk   (aclk_i),
        .rst_n (arstn_i),
        .state (lfsr)
    );

    assign gate   = lfsr[0];
    assign unused = ^{awprot_i, arprot_i, lfsr[15:1]};
`else
    assign gate   = 1'b1;
    assign unused = ^{awprot_i, arprot_i};
`endif

    // rdy_en keeps every ready low until the first edge after reset
    assign awready_o = rdy_en & gate & (w_state == W_IDLE) & ~aw_held;
    assign wready_o  = rdy_en & gate & (w_state == W_IDLE) & ~w_held;
    assign arready_o = rdy_en & gate & (r_state == R_IDLE);

    assign aw_hs  = awvalid_i & awready_o;
    assign w_hs   = wvalid_i & wready_o;
    assign b_hs   = bvalid_o & bready_i;
    assign ar_hs  = arvalid_i & arready_o;
    assign commit = (w_state == W_IDLE) & aw_held & w_held;
    assign r_load = (r_state == R_WAIT) & (r_cnt == 4'd0);

    assign bvalid_o = (w_state == W_RESP);
    assign bresp_o  = bresp;
    assign rvalid_o = (r_state == R_RESP);
    assign rresp_o  = rresp;

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (commit) w_next = W_RESP;
            W_RESP:  if (bready_i) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_WAIT;
            R_WAIT:  if (r_cnt == 4'd0) r_next = R_RESP;
            R_RESP:  if (rready_i) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rdy_en  <= 1'b0;
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp   <= RESP_OKAY;
        end else begin
            rdy_en  <= 1'b1;
            w_state <= w_next;
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= awaddr_i;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= wdata_i;
                w_strb <= wstrb_i;
            end
            if (commit)
                bresp <= in_range(aw_addr) ? RESP_OKAY : RESP_SLVERR;
            if (b_hs) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk_i) begin
        if (commit && in_range(aw_addr))
            for (int b = 0; b < DATA_BYTES; b++)
                if (w_strb[b])
                    mem[aw_addr[OFF +: IW]][8*b +: 8] <= w_data[8*b +: 8];
    end

    // a read loading at the same edge as a write commit sees the old word
    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            ar_addr <= '0;
            rdata_o <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                ar_addr <= araddr_i;
                r_cnt   <= 4'(READ_LATENCY - 1);
            end else if (r_state == R_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_load) begin
                rdata_o <= in_range(ar_addr) ? mem[ar_addr[OFF +: IW]] : '0;
                rresp   <= in_range(ar_addr) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axi_4_lite_slave_mem.sv
// Scoreboard bench for axi_4_lite_slave_mem: round trip, strobes,
// out-of-range, held responses, reset abort, concurrency, throughput.
module tb_axi_4_lite_slave_mem;
    import cache_pkg::*;

    localparam int RL    = 3;
    localparam int DEPTH = 1024;
    localparam int TMO   = 100;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic        aclk = 1'b0;
    logic        arstn;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    logic [1:0]  bq [$];
    r_exp_t      rq [$];
    logic [31:0] model [int];
    int          checks = 0;
    int          errors = 0;

    always #5 aclk = ~aclk;

    axi_4_lite_slave_mem #(
        .MEM_DEPTH    (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .aclk_i    (aclk),
        .arstn_i   (arstn),
        .awvalid_i (awvalid),
        .awready_o (awready),
        .awaddr_i  (awaddr),
        .awprot_i  (awprot),
        .wvalid_i  (wvalid),
        .wready_o  (wready),
        .wdata_i   (wdata),
        .wstrb_i   (wstrb),
        .bvalid_o  (bvalid),
        .bready_i  (bready),
        .bresp_o   (bresp),
        .arvalid_i (arvalid),
        .arready_o (arready),
        .araddr_i  (araddr),
        .arprot_i  (arprot),
        .rvalid_o  (rvalid),
        .rready_i  (rready),
        .rdata_o   (rdata),
        .rresp_o   (rresp)
    );

    function automatic logic in_rng(input logic [31:0] a);
        return (a >> 2) < 32'(DEPTH);
    endfunction

    function automatic void model_write(input logic [31:0] a,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
        logic [31:0] v;
        if (!in_rng(a)) return;
        v = model.exists(int'(a >> 2)) ? model[int'(a >> 2)] : 32'h0;
        for (int b = 0; b < 4; b++)
            if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        model[int'(a >> 2)] = v;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        awvalid = 1'b1;
        awaddr  = a;
        while (!awready && n < TMO) begin tick(); n++; end
        if (!awready) begin
            checks++; errors++;
            $display("FAIL aw_timeout awready=%b required=1", awready);
        end
        tick();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
        while (!wready && n < TMO) begin tick(); n++; end
        if (!wready) begin
            checks++; errors++;
            $display("FAIL w_timeout wready=%b required=1", wready);
        end
        tick();
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        arvalid = 1'b1;
        araddr  = a;
        while (!arready && n < TMO) begin tick(); n++; end
        if (!arready) begin
            checks++; errors++;
            $display("FAIL ar_timeout arready=%b required=1", arready);
        end
        tick();
        arvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output int lat);
        lat = 0;
        while (!bvalid && lat < TMO) begin tick(); lat++; end
        if (!bvalid) begin
            checks++; errors++;
            $display("FAIL b_timeout bvalid=%b required=1", bvalid);
        end
        resp   = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic wait_r(output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
        lat = 0;
        while (!rvalid && lat < TMO) begin tick(); lat++; end
        if (!rvalid) begin
            checks++; errors++;
            $display("FAIL r_timeout rvalid=%b required=1", rvalid);
        end
        d      = rdata;
        resp   = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic issue_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        bq.push_back(in_rng(a) ? 2'b00 : 2'b10);
        model_write(a, d, s);
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic issue_read(input logic [31:0] a);
        r_exp_t e;
        e.resp = in_rng(a) ? 2'b00 : 2'b10;
        e.data = in_rng(a) ? model[int'(a >> 2)] : 32'h0;
        rq.push_back(e);
        send_ar(a);
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b0
            || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%b rdata=%h required=0",
                     {awready, wready, arready, bvalid, rvalid, bresp, rresp}, rdata);
        end
        arstn = 1'b1;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++;
            $display("FAIL ready_before_edge got=%b required=000",
                     {awready, wready, arready});
        end
        tick();
`ifndef AXI_SLV_BACKPRESSURE_EN
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_edge got=%b required=111",
                     {awready, wready, arready});
        end
`endif
    endtask

    task automatic test_round_trip();
        logic [1:0]  resp, eb;
        logic [31:0] d;
        int          lat;
        r_exp_t      er;
        bq.push_back(2'b00);
        model_write(32'h10, 32'hDEADBEEF, 4'hF);
        send_w(32'hDEADBEEF, 4'hF);
        tick();
        send_aw(32'h10);
        wait_b(resp, lat);
        eb = bq.pop_front();
        checks++;
        if (resp !== eb || lat != 1) begin
            errors++;
            $display("FAIL rt_bresp got=%b lat=%0d required=%b lat=1", resp, lat, eb);
        end
        issue_read(32'h10);
        wait_r(d, resp, lat);
        er = rq.pop_front();
        checks++;
        if (d !== er.data || resp !== er.resp) begin
            errors++;
            $display("FAIL rt_rdata got=%h/%b required=%h/%b", d, resp, er.data, er.resp);
        end
        checks++;
        if (lat != RL) begin
            errors++;
            $display("FAIL rt_rlat got=%0d required=%0d", lat, RL);
        end
    endtask

    task automatic test_partial_strobe();
        logic [1:0]  resp, eb;
        logic [31:0] d;
        int          lat;
        r_exp_t      er;
        issue_write(32'h10, 32'h11223344, 4'b0101);
        wait_b(resp, lat);
        eb = bq.pop_front();
        checks++;
        if (resp !== eb) begin
            errors++;
            $display("FAIL strb_bresp got=%b required=%b", resp, eb);
        end
        issue_read(32'h10);
        wait_r(d, resp, lat);
        er = rq.pop_front();
        checks++;
        if (d !== er.data || d !== 32'hDE22BE44 || resp !== er.resp) begin
            errors++;
            $display("FAIL strb_rdata got=%h/%b required=%h/%b", d, resp, er.data, er.resp);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0]  resp, eb;
        logic [31:0] d;
        logic [31:0] addrs [3];
        int          lat;
        r_exp_t      er;
        addrs[0] = 32'h0;
        addrs[1] = 32'(DEPTH * 4);
        addrs[2] = 32'(DEPTH * 4 - 4);
        for (int i = 0; i < 3; i++) begin
            issue_write(addrs[i], 32'hCAFE0000 | 32'(i), 4'hF);
            wait_b(resp, lat);
            eb = bq.pop_front();
            checks++;
            if (resp !== eb) begin
                errors++;
                $display("FAIL oor_bresp addr=%h got=%b required=%b", addrs[i], resp, eb);
            end
        end
        for (int i = 0; i < 3; i++) begin
            issue_read(addrs[i]);
            wait_r(d, resp, lat);
            er = rq.pop_front();
            checks++;
            if (d !== er.data || resp !== er.resp) begin
                errors++;
                $display("FAIL oor_read addr=%h got=%h/%b required=%h/%b",
                         addrs[i], d, resp, er.data, er.resp);
            end
        end
    endtask

    task automatic test_held_bresp();
        logic [1:0] resp, eb;
        int         lat;
        issue_write(32'h14, 32'h0BADF00D, 4'hF);
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
                errors++;
                $display("FAIL held_b cyc=%0d got=%b required=10000",
                         i, {bvalid, bresp, awready, wready});
            end
            tick();
        end
        wait_b(resp, lat);
        eb = bq.pop_front();
        checks++;
        if (resp !== eb || lat != 0) begin
            errors++;
            $display("FAIL held_bresp got=%b lat=%0d required=%b lat=0", resp, lat, eb);
        end
    endtask

    task automatic test_reset_mid_read();
        int beats = 0;
        send_ar(32'h10);
        arstn = 1'b0;
        #1;
        checks++;
        if ({rvalid, arready} !== 2'b00) begin
            errors++;
            $display("FAIL rst_read got=%b required=00", {rvalid, arready});
        end
        tick();
        tick();
        arstn = 1'b1;
        tick();
`ifndef AXI_SLV_BACKPRESSURE_EN
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL rst_arready got=%b required=1", arready);
        end
`endif
        for (int i = 0; i < 10; i++) begin
            if (rvalid !== 1'b0) beats++;
            tick();
        end
        checks++;
        if (beats != 0) begin
            errors++;
            $display("FAIL rst_no_beat got=%0d required=0", beats);
        end
    endtask

    task automatic test_concurrent();
        logic [1:0]  br, rr, eb;
        logic [31:0] rd;
        int          bl, rl;
        r_exp_t      er;
        fork
            begin issue_write(32'h20, 32'h55AA1234, 4'hF); wait_b(br, bl); end
            begin issue_read(32'h10); wait_r(rd, rr, rl); end
        join
        eb = bq.pop_front();
        er = rq.pop_front();
        checks++;
        if (br !== eb) begin
            errors++;
            $display("FAIL conc_bresp got=%b required=%b", br, eb);
        end
        checks++;
        if (rd !== er.data || rr !== er.resp) begin
            errors++;
            $display("FAIL conc_read got=%h/%b required=%h/%b", rd, rr, er.data, er.resp);
        end
        issue_read(32'h20);
        wait_r(rd, rr, rl);
        er = rq.pop_front();
        checks++;
        if (rd !== er.data || rr !== er.resp) begin
            errors++;
            $display("FAIL conc_readback got=%h/%b required=%h/%b", rd, rr, er.data, er.resp);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  resp, eb;
        logic [31:0] d;
        int          lat;
        time         t0;
        r_exp_t      er;
        t0 = $time;
        for (int i = 0; i < 4; i++) begin
            issue_write(32'h40 + 32'(4 * i), $urandom, 4'hF);
            wait_b(resp, lat);
            eb = bq.pop_front();
            checks++;
            if (resp !== eb || lat != 1) begin
                errors++;
                $display("FAIL b2b_w%0d got=%b lat=%0d required=%b lat=1", i, resp, lat, eb);
            end
        end
`ifndef AXI_SLV_BACKPRESSURE_EN
        checks++;
        if ($time - t0 != 4 * 3 * 10) begin
            errors++;
            $display("FAIL b2b_wrate got=%0t required=%0d", $time - t0, 4 * 3 * 10);
        end
`endif
        t0 = $time;
        for (int i = 0; i < 4; i++) begin
            issue_read(32'h40 + 32'(4 * i));
            wait_r(d, resp, lat);
            er = rq.pop_front();
            checks++;
            if (d !== er.data || resp !== er.resp || lat != RL) begin
                errors++;
                $display("FAIL b2b_r%0d got=%h/%b lat=%0d required=%h/%b lat=%0d",
                         i, d, resp, lat, er.data, er.resp, RL);
            end
        end
`ifndef AXI_SLV_BACKPRESSURE_EN
        checks++;
        if ($time - t0 != 4 * (RL + 2) * 10) begin
            errors++;
            $display("FAIL b2b_rrate got=%0t required=%0d", $time - t0, 4 * (RL + 2) * 10);
        end
`endif
    endtask

    initial begin
        arstn   = 1'b0;
        awvalid = 1'b0; awaddr = '0; awprot = 3'b0;
        wvalid  = 1'b0; wdata  = '0; wstrb  = '0;
        bready  = 1'b0;
        arvalid = 1'b0; araddr = '0; arprot = 3'b0;
        rready  = 1'b0;
        test_reset();
        test_round_trip();
        test_partial_strobe();
        test_out_of_range();
        test_held_bresp();
        test_reset_mid_read();
        test_concurrent();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $fatal(1);
    end

endmodule
